// File: rtl/dmem_bus_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : dmem_lsu_pkg
//  Description : Shared encodings for the data-memory load/store unit.
//                Contents: access-size codes, op-field bit positions, FSM
//                state type, and helpers that derive lane count and
//                byte-offset width from the bus data width.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_lsu_pkg;

    // Access size codes carried in op[1:0].
    localparam logic [1:0] SZ_WORD  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_DWORD = 2'b10;
    localparam logic [1:0] SZ_BYTE  = 2'b11;

    // Bit positions inside the 4-bit op field {store, sign, size[1:0]}.
    localparam int OP_STORE_BIT = 3;
    localparam int OP_SIGN_BIT  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    // Number of byte lanes on a bus of the given data width.
    function automatic int lanes_of(input int dw);
        return dw / 8;
    endfunction

    // Number of address bits that select a byte within one bus word.
    function automatic int off_bits_of(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bus_lsu_xlate.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lane_xlate
//  Description : Combinational byte-lane translator (big-endian lanes).
//                Store path: shifts LSB-justified store data into its lanes
//                and builds the byte enables. Load path: pulls the selected
//                lanes down to the LSBs and zero/sign-extends them. Also
//                reports whether the access is aligned and legal.
//  Ports       : size_i     access size code
//                sign_i     sign-extend loads when set
//                addr_lo_i  low three byte-address bits
//                wdata_i    LSB-justified store data
//                rdata_i    raw bus read data
//                legal_o    size is supported at this data width
//                aligned_o  address is naturally aligned for the size
//                byteena_o  lane enables, MSB = byte offset 0
//                wdata_o    lane-shifted store data
//                rdata_o    selected and extended load data
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_xlate
    import dmem_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]                      size_i,
    input  logic                            sign_i,
    input  logic [2:0]                      addr_lo_i,
    input  logic [DATA_WIDTH-1:0]           wdata_i,
    input  logic [DATA_WIDTH-1:0]           rdata_i,
    output logic                            legal_o,
    output logic                            aligned_o,
    output logic [lanes_of(DATA_WIDTH)-1:0] byteena_o,
    output logic [DATA_WIDTH-1:0]           wdata_o,
    output logic [DATA_WIDTH-1:0]           rdata_o
);

    localparam int NB = lanes_of(DATA_WIDTH);
    localparam int OW = off_bits_of(DATA_WIDTH);

    logic [3:0]            w_nbytes;
    logic [NB-1:0]         w_bemask;
    logic [DATA_WIDTH-1:0] w_dmask;
    logic [3:0]            w_lane_sh;
    logic [6:0]            w_bit_sh;
    logic [DATA_WIDTH-1:0] w_rsh;
    logic [DATA_WIDTH-1:0] w_word_ext;

    always_comb begin
        w_nbytes  = 4'd8;
        w_bemask  = '1;
        w_dmask   = '1;
        aligned_o = (addr_lo_i == 3'b000);
        case (size_i)
            SZ_BYTE: begin
                w_nbytes  = 4'd1;
                w_bemask  = NB'(1);
                w_dmask   = DATA_WIDTH'(8'hFF);
                aligned_o = 1'b1;
            end
            SZ_HALF: begin
                w_nbytes  = 4'd2;
                w_bemask  = NB'(3);
                w_dmask   = DATA_WIDTH'(16'hFFFF);
                aligned_o = ~addr_lo_i[0];
            end
            SZ_WORD: begin
                w_nbytes  = 4'd4;
                w_bemask  = NB'(15);
                w_dmask   = DATA_WIDTH'(32'hFFFF_FFFF);
                aligned_o = (addr_lo_i[1:0] == 2'b00);
            end
            default: begin
                w_nbytes  = 4'd8;
                w_bemask  = '1;
                w_dmask   = '1;
                aligned_o = (addr_lo_i == 3'b000);
            end
        endcase
    end

    assign legal_o = (size_i != SZ_DWORD) || (DATA_WIDTH == 64);

    // Byte offset k of an S-byte access lives in lanes NB-1-k down to NB-S-k,
    // so the lane shift from the LSBs is NB-S-k. For illegal or misaligned
    // accesses the value wraps, but those never reach the bus.
    assign w_lane_sh = 4'(NB) - w_nbytes - 4'(addr_lo_i[OW-1:0]);
    assign w_bit_sh  = {w_lane_sh, 3'b000};

    assign byteena_o = w_bemask << w_lane_sh;
    assign wdata_o   = (wdata_i & w_dmask) << w_bit_sh;
    assign w_rsh     = rdata_i >> w_bit_sh;

    // Word loads only need extending when the bus is wider than a word.
    if (DATA_WIDTH > 32) begin : g_word_ext
        assign w_word_ext = {{(DATA_WIDTH-32){sign_i & w_rsh[31]}}, w_rsh[31:0]};
    end else begin : g_word_plain
        assign w_word_ext = w_rsh;
    end

    always_comb begin
        rdata_o = w_rsh;
        case (size_i)
            SZ_BYTE: rdata_o = {{(DATA_WIDTH-8){sign_i & w_rsh[7]}}, w_rsh[7:0]};
            SZ_HALF: rdata_o = {{(DATA_WIDTH-16){sign_i & w_rsh[15]}}, w_rsh[15:0]};
            SZ_WORD: rdata_o = w_word_ext;
            default: rdata_o = w_rsh;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_bus_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_bus_lsu
//  Description : Load/store unit bridging pipeline memory requests onto a
//                variable-latency req/ack data bus. Holds the pipeline while
//                a transfer is outstanding, flags misaligned/illegal requests
//                and reports bus timeouts.
//  Ports       : clk_i, reset_i       clock, synchronous active-high reset
//                en_i, req_valid_i    pipeline enable and request strobe
//                op_i                 {store, sign, size[1:0]}
//                addr_i, wdata_i      byte address, LSB-justified store data
//                stall_o              pipeline hold
//                load_valid_o         one-cycle pulse, load_result_o valid
//                load_result_o        extended load data
//                misalign_o           one-cycle pulse, request rejected
//                bus_err_o            one-cycle pulse, transfer timed out
//                mem_req_o/mem_wr_o   bus request / write flag
//                mem_addr_o           bus word address
//                mem_byteena_o        lane enables, MSB = byte offset 0
//                mem_wdata_o          lane-shifted store data
//                mem_ack_i/mem_rdata_i transfer complete / read data
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_bus_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,
    input  logic                                       en_i,
    input  logic                                       req_valid_i,
    input  logic [3:0]                                 op_i,
    input  logic [ADDR_WIDTH-1:0]                      addr_i,
    input  logic [DATA_WIDTH-1:0]                      wdata_i,
    output logic                                       stall_o,
    output logic                                       load_valid_o,
    output logic [DATA_WIDTH-1:0]                      load_result_o,
    output logic                                       misalign_o,
    output logic                                       bus_err_o,
    output logic                                       mem_req_o,
    output logic                                       mem_wr_o,
    output logic [ADDR_WIDTH-off_bits_of(DATA_WIDTH)-1:0] mem_addr_o,
    output logic [lanes_of(DATA_WIDTH)-1:0]            mem_byteena_o,
    output logic [DATA_WIDTH-1:0]                      mem_wdata_o,
    input  logic                                       mem_ack_i,
    input  logic [DATA_WIDTH-1:0]                      mem_rdata_i
);

    localparam int NB = lanes_of(DATA_WIDTH);
    localparam int OW = off_bits_of(DATA_WIDTH);
    localparam int MW = ADDR_WIDTH - OW;

    lsu_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [MW-1:0]         mem_addr_q, mem_addr_d;
    logic [NB-1:0]         mem_be_q, mem_be_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]            off_q, off_d;
    logic [2:0]            op_q, op_d;
    logic                  load_valid_q, load_valid_d;
    logic [DATA_WIDTH-1:0] load_result_q, load_result_d;
    logic                  misalign_q, misalign_d;
    logic                  bus_err_q, bus_err_d;

    logic                  w_idle;
    logic [1:0]            w_x_size;
    logic [2:0]            w_x_off;
    logic                  w_legal, w_aligned;
    logic [NB-1:0]         w_be;
    logic [DATA_WIDTH-1:0] w_st_data, w_ld_data;
    logic                  w_req, w_accept, w_reject, w_timeout;

    // One translator serves both directions: in IDLE it looks at the
    // incoming request (store lanes, alignment), in BUSY at the captured
    // request (load lane select and extension).
    assign w_idle   = (state_q == ST_IDLE);
    assign w_x_size = w_idle ? op_i[1:0]   : op_q[1:0];
    assign w_x_off  = w_idle ? addr_i[2:0] : off_q;

    dmem_lane_xlate #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_xlate (
        .size_i    (w_x_size),
        .sign_i    (op_q[OP_SIGN_BIT]),
        .addr_lo_i (w_x_off),
        .wdata_i   (wdata_i),
        .rdata_i   (mem_rdata_i),
        .legal_o   (w_legal),
        .aligned_o (w_aligned),
        .byteena_o (w_be),
        .wdata_o   (w_st_data),
        .rdata_o   (w_ld_data)
    );

    // Reset is folded into the request qualifier so that no output goes
    // active while reset is asserted.
    assign w_req     = req_valid_i & en_i & ~reset_i;
    assign w_accept  = w_req & w_legal & w_aligned;
    assign w_reject  = w_req & ~(w_legal & w_aligned);
    assign w_timeout = (TIMEOUT_CYCLES != 0) &&
                       (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_req_d     = mem_req_q;
        mem_wr_d      = mem_wr_q;
        mem_addr_d    = mem_addr_q;
        mem_be_d      = mem_be_q;
        mem_wdata_d   = mem_wdata_q;
        off_d         = off_q;
        op_d          = op_q;
        load_result_d = load_result_q;
        load_valid_d  = 1'b0;
        misalign_d    = 1'b0;
        bus_err_d     = 1'b0;
        stall_o       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stall_o = w_accept;
                if (w_accept) begin
                    state_d     = ST_BUSY;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_wr_d    = op_i[OP_STORE_BIT];
                    mem_addr_d  = addr_i[ADDR_WIDTH-1:OW];
                    mem_be_d    = w_be;
                    mem_wdata_d = w_st_data;
                    off_d       = addr_i[2:0];
                    op_d        = op_i[2:0];
                end else if (w_reject) begin
                    misalign_d = 1'b1;
                end
            end

            ST_BUSY: begin
                stall_o = 1'b1;
                // An ack in the timeout cycle still completes normally.
                if (mem_ack_i) begin
                    state_d      = ST_DONE;
                    mem_req_d    = 1'b0;
                    load_valid_d = ~mem_wr_q;
                    if (!mem_wr_q) begin
                        load_result_d = w_ld_data;
                    end
                end else if (w_timeout) begin
                    state_d       = ST_DONE;
                    mem_req_d     = 1'b0;
                    load_valid_d  = ~mem_wr_q;
                    load_result_d = '0;
                    bus_err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                // Pipeline is released here; the request still on the
                // inputs is the one just completed, so it is not taken.
                cnt_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            mem_req_q     <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_be_q      <= '0;
            mem_wdata_q   <= '0;
            off_q         <= '0;
            op_q          <= '0;
            load_valid_q  <= 1'b0;
            load_result_q <= '0;
            misalign_q    <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_req_q     <= mem_req_d;
            mem_wr_q      <= mem_wr_d;
            mem_addr_q    <= mem_addr_d;
            mem_be_q      <= mem_be_d;
            mem_wdata_q   <= mem_wdata_d;
            off_q         <= off_d;
            op_q          <= op_d;
            load_valid_q  <= load_valid_d;
            load_result_q <= load_result_d;
            misalign_q    <= misalign_d;
            bus_err_q     <= bus_err_d;
        end
    end

    assign load_valid_o  = load_valid_q;
    assign load_result_o = load_result_q;
    assign misalign_o    = misalign_q;
    assign bus_err_o     = bus_err_q;
    assign mem_req_o     = mem_req_q;
    assign mem_wr_o      = mem_wr_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_byteena_o = mem_be_q;
    assign mem_wdata_o   = mem_wdata_q;

endmodule
`default_nettype wire
